// File: rtl/chi_pkg.sv
// Shared CHI link-layer flit types, opcodes and node IDs.
// Used by chi_rx_lcrd_chan and the testbench.
package chi_pkg;

    localparam int CHI_NID_W      = 7;
    localparam int CHI_OPC_W      = 6;
    localparam int MAX_LCRD_LIMIT = 15;

    localparam logic [CHI_OPC_W-1:0] LCRD_RETURN = '0;

    localparam logic [CHI_NID_W-1:0] HNF_NID  = 7'd0;
    localparam logic [CHI_NID_W-1:0] RNF0_NID = 7'd1;

    typedef struct packed {
        logic [31:0]          data;
        logic [CHI_NID_W-1:0] srcid;
        logic [CHI_NID_W-1:0] tgtid;
        logic [CHI_OPC_W-1:0] opcode;
    } reqflit_t;

    localparam int REQ_OPC_LSB = 0;
    localparam int REQ_TGT_LSB = CHI_OPC_W;

endpackage

// File: rtl/chi_rx_lcrd_chan_sfifo.sv
// Synchronous show-ahead FIFO; head entry is always visible on rd_data.
// Full + simultaneous read/write keeps the count steady.
module sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    always_comb begin
        do_rd    = rd_en && (count_q != '0);
        do_wr    = wr_en && ((count_q != CW'(DEPTH)) || do_rd);
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;

endmodule

// File: rtl/chi_rx_lcrd_chan.sv
// CHI RX channel: L-credit issue/consume, link FSM and flit buffering.
// Define CHI_RX_CHECK_EN to build the sticky protocol checker.
module chi_rx_lcrd_chan
    import chi_pkg::*;
#(
    parameter int FLIT_W   = $bits(reqflit_t),
    parameter int DEPTH    = 8,
    parameter int MAX_LCRD = 8,
    parameter int OPC_LSB  = 0,
    parameter int OPC_W    = 6,
    parameter int TGT_LSB  = 0,
    parameter logic [CHI_NID_W-1:0] MY_NID = 7'd0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              link_act,
    output logic              link_idle,
    input  logic [FLIT_W-1:0] RXFLIT,
    input  logic              RXFLITV,
    input  logic              RXFLITPEND,
    output logic              RXLCRDV,
    output logic [FLIT_W-1:0] deq_flit,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [CW-1:0]     occupancy,
    output logic [3:0]        crd_out,
    output logic              err_sticky
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DEACT = 2'd2;
    localparam int SW = ((CW > 4) ? CW : 4) + 1;

    logic [1:0]       state_q, state_d;
    logic [3:0]       crd_q, crd_d;
    logic             lcrdv_q, lcrdv_d;
    logic             grant, enq, fifo_empty, unused_full;
    logic [SW-1:0]    crd_sum;
    logic [OPC_W-1:0] opc;

    assign opc     = RXFLIT[OPC_LSB +: OPC_W];
    assign enq     = RXFLITV && (opc != OPC_W'(LCRD_RETURN));
    assign crd_sum = SW'(crd_q) + SW'(occupancy);
    // Counting buffered flits too guarantees every granted credit has a slot.
    assign grant   = (state_q == ST_RUN) &&
                     (crd_q < 4'(MAX_LCRD)) &&
                     (crd_sum < SW'(DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (link_act) state_d = ST_RUN;
            ST_RUN:   if (!link_act) state_d = ST_DEACT;
            ST_DEACT: begin
                if (link_act)          state_d = ST_RUN;
                else if (crd_q == '0)  state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        crd_d   = crd_q;
        lcrdv_d = grant;
        if (grant && !RXFLITV)
            crd_d = crd_q + 4'd1;
        else if (!grant && RXFLITV && (crd_q != '0))
            crd_d = crd_q - 4'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            crd_q   <= '0;
            lcrdv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crd_q   <= crd_d;
            lcrdv_q <= lcrdv_d;
        end
    end

    sfifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (~reset),
        .wr_en   (enq),
        .wr_data (RXFLIT),
        .full    (unused_full),
        .rd_en   (deq_ready),
        .rd_data (deq_flit),
        .empty   (fifo_empty),
        .count   (occupancy)
    );

    assign deq_valid = ~fifo_empty;
    assign RXLCRDV   = lcrdv_q;
    assign crd_out   = crd_q;
    assign link_idle = (state_q == ST_IDLE) && (crd_q == '0);

`ifdef CHI_RX_CHECK_EN
    logic                 pend_q, pend_d;
    logic                 err_q, err_d;
    logic                 no_crd, no_pend, bad_tgt;
    logic [CHI_NID_W-1:0] tgt;

    assign tgt = RXFLIT[TGT_LSB +: CHI_NID_W];

    always_comb begin
        no_crd  = RXFLITV && (crd_q == '0);
        no_pend = RXFLITV && !pend_q;
        bad_tgt = enq && (tgt != MY_NID);
        pend_d  = RXFLITPEND;
        err_d   = err_q | no_crd | no_pend | bad_tgt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign err_sticky = err_q;

    a_no_crd: assert property (@(posedge clock) disable iff (reset) !no_crd)
        else $error("chi_rx_lcrd_chan: flit received with no credit");
    a_no_pend: assert property (@(posedge clock) disable iff (reset) !no_pend)
        else $error("chi_rx_lcrd_chan: flit without prior FLITPEND");
    a_bad_tgt: assert property (@(posedge clock) disable iff (reset) !bad_tgt)
        else $error("chi_rx_lcrd_chan: flit TgtID mismatch");
`else
    logic unused_pend;
    assign unused_pend = RXFLITPEND;
    assign err_sticky  = 1'b0;
`endif

endmodule
